dma_io_packer: RTL and testbench
================================

# dma_io_packer

Downstream consumer of the DUT core outputs: captures each 4064-bit `out_io_data` snapshot qualified by `out_step`/`out_enable`, buffers up to two frames, and serialises each frame as eight 512-bit AXI-Stream beats toward the XDMA C2H channel. It sits between `dut_wrapper` and the XDMA stream interface in the `xdma_clk` domain. A 32-bit sequence number pads each frame to 4096 bits. Frames arriving while both buffers are full are dropped and counted.

## Interface
Parameters:
- `DATA_W`, 4064, captured DUT payload width
- `BEAT_W`, 512, stream beat width
- `BEATS`, 8, beats per frame; BEATS*BEAT_W = DATA_W + 32

Ports:
- `xdma_clk` in 1: sole clock
- `xdma_resetn` in 1: asynchronous, active-low reset
- `in_enable` in 1: DUT output valid window (`out_enable`)
- `in_step` in 1: one-cycle step pulse (`out_step`)
- `in_io_data` in 4064: DUT snapshot (`out_io_data`)
- `m_axis_tdata` out 512: stream data
- `m_axis_tkeep` out 64: byte enables, constant all-ones
- `m_axis_tlast` out 1: last beat of frame
- `m_axis_tvalid` out 1: beat valid
- `m_axis_tready` in 1: sink ready
- `frame_cnt` out 32: frames fully sent (wraps)
- `drop_cnt` out 32: frames dropped (wraps)
- `busy` out 1: any frame buffered or in flight

All inputs are synchronous to `xdma_clk`. Upstream CDC is outside this block.

## Operation
- Capture condition: `in_step & in_enable` sampled on a rising edge.
- Two-slot frame buffer (ping-pong) with a 1-bit write pointer `wp`, a 1-bit read pointer `rp`, and a 2-bit `occ` (0..2).
- On capture with a free slot, the slot receives `{seq[31:0], in_io_data}` (seq in bits [4095:4064]). `seq` then increments. `seq` counts accepted frames only, starting at 0.
- On capture with `occ==2` and no frame completing in the same cycle, the frame is dropped, `drop_cnt`+1, and `seq` is unchanged.
- On capture in the same cycle that the last beat of a frame is accepted with `occ==2`, the capture is accepted. `occ` stays 2.
- Sender FSM has two states:
  - IDLE: `tvalid`=0. Goes to SEND when `occ>0`.
  - SEND: presents beat `k` (3-bit `beat`) = slot[rp] bits [512k+511:512k], with `tlast`=(k==7). On `tvalid&tready`, `beat`+1. On the last-beat handshake: `rp` toggles, `occ`-1, `frame_cnt`+1, `beat`=0. The FSM stays in SEND if the remaining `occ>0`, otherwise it returns to IDLE.
- `tdata`, `tlast`, and `tvalid` are held stable while `tvalid & ~tready`. A buffered slot is never overwritten while it is being read.
- `busy` = (`occ`!=0).

## Timing
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0, `tkeep`=all-ones, `frame_cnt`=0, `drop_cnt`=0, `busy`=0. Also `seq`=0, `wp`=`rp`=0, `occ`=0, `beat`=0, FSM=IDLE.
- Latency: capture at edge N gives `tvalid`=1 with beat 0 from cycle N+1 when the FSM was IDLE.
- Throughput: 8 cycles per frame with `tready` held high. Back-to-back frames have no idle cycle between `tlast` and the next beat 0.
- Sustained capture rate above one per 8 cycles fills the buffer. Afterwards only one capture per completed frame is accepted.
- Reset asserted mid-frame: outputs go to reset values immediately (async). Partial frames are discarded and the sink must tolerate the truncation.
- Counters wrap from 0xFFFFFFFF to 0 silently.

## Structure
- Shared package `dma_pkg`: `BEAT_W`, `BEATS`, `DATA_W`, `SEQ_W`=32, and the FSM state enum `{S_IDLE, S_SEND}`.
- One natural sub-module: `frame_pingpong_buf` (2×4096-bit storage, `wp`/`rp`/`occ`, write and read-beat mux). The sender FSM and counters stay in the top module.

## Test plan
- Single frame: one capture of data with bits[i]=i%2, `tready`=1 → beats 0..7 appear on cycles N+1..N+8. `tlast` is asserted only on beat 7. Beat 7 bits [511:480]=0 (seq). `frame_cnt`=1.
- Backpressure: `tready` toggles 1/0 each cycle → each beat is held stable while stalled. A frame takes 16 cycles and the data matches the single-frame case.
- Overflow: `tready`=0, 3 captures → `occ`=2, `drop_cnt`=1. After `tready`=1, two frames are sent with seq 0 and 1, back-to-back with no gap.
- Simultaneous: `occ`=2, capture coincides with the last-beat handshake → capture accepted, `drop_cnt` unchanged, next seq=2.
- `in_step` with `in_enable`=0 → no capture, `busy` stays 0.
- Reset mid-frame at beat 3 → `tvalid`=0 immediately. After release, a new capture is sent with seq=0 and `frame_cnt`=1.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and the sender state encoding for the DMA I/O packer.
package dma_pkg;

  localparam int DATA_W     = 4064;
  localparam int BEAT_W     = 512;
  localparam int BEATS      = 8;
  localparam int SEQ_W      = 32;
  localparam int FRAME_W    = BEATS * BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int KEEP_W     = BEAT_W / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-slot frame store with write/read pointers and occupancy.
// A write is accepted when a slot is free or the frame being read
// completes in the same cycle; the slot being read is never written
// because a full buffer only frees slot rp at the completing edge.
module frame_pingpong_buf
  import dma_pkg::*;
#(
  parameter int P_FRAME_W = FRAME_W,
  parameter int P_BEAT_W  = BEAT_W,
  parameter int P_IDX_W   = BEAT_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [P_FRAME_W-1:0] wr_data,
  input  logic                 rd_done,
  input  logic [P_IDX_W-1:0]   rd_beat,
  output logic                 wr_accept,
  output logic [1:0]           occ,
  output logic [1:0]           occ_next,
  output logic [P_BEAT_W-1:0]  rd_data
);

  logic                 wp_q, wp_d;
  logic                 rp_q, rp_d;
  logic [1:0]           occ_q, occ_d;
  logic [P_FRAME_W-1:0] slot_mem [2];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_accept = wr_req & ((occ_q != 2'd2) | rd_done);
    wp_d      = wp_q ^ wr_accept;
    rp_d      = rp_q ^ rd_done;
    occ_d     = occ_q + {1'b0, wr_accept} - {1'b0, rd_done};
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end

  // Frame storage; contents are only meaningful while occupied, so no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) slot_mem[wp_q] <= wr_data;
  end

  assign occ      = occ_q;
  assign occ_next = occ_d;
  assign rd_data  = slot_mem[rp_q][rd_beat*P_BEAT_W +: P_BEAT_W];

endmodule

// File: rtl/dma_io_packer.sv
// Captures DUT snapshots on step&enable, tags each with a sequence number,
// buffers up to two frames and streams each as eight AXI-Stream beats.
// Stream handshake: a beat transfers on a rising edge where tvalid and
// tready are both high; while tvalid is high and tready low, tdata, tlast
// and tvalid hold their values until the transfer happens.
module dma_io_packer
  import dma_pkg::*;
#(
  parameter int DATA_W = dma_pkg::DATA_W,
  parameter int BEAT_W = dma_pkg::BEAT_W,
  parameter int BEATS  = dma_pkg::BEATS
) (
  input  logic              xdma_clk,
  input  logic              xdma_resetn,
  input  logic              in_enable,
  input  logic              in_step,
  input  logic [DATA_W-1:0] in_io_data,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic [BEAT_W/8-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       frame_cnt,
  output logic [31:0]       drop_cnt,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;

  logic               capture;
  logic               wr_accept;
  logic               hs;
  logic               last_hs;
  logic [1:0]         occ;
  logic [1:0]         occ_next;
  logic [BEAT_W-1:0]  rd_data;

  assign capture = in_step & in_enable;
  assign hs      = m_axis_tvalid & m_axis_tready;
  assign last_hs = hs & (beat_q == LAST_BEAT);

  frame_pingpong_buf #(
    .P_FRAME_W (BEATS * BEAT_W),
    .P_BEAT_W  (BEAT_W),
    .P_IDX_W   (IDX_W)
  ) u_buf (
    .clk       (xdma_clk),
    .rst_n     (xdma_resetn),
    .wr_req    (capture),
    .wr_data   ({seq_q, in_io_data}),
    .rd_done   (last_hs),
    .rd_beat   (beat_q),
    .wr_accept (wr_accept),
    .occ       (occ),
    .occ_next  (occ_next),
    .rd_data   (rd_data)
  );

  // Sender next-state: leave IDLE on the same edge a frame lands so beat 0
  // is valid the very next cycle; stay in SEND while frames remain.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (occ_next != 2'd0) state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) beat_d = beat_q + 1'b1;
        if (last_hs) begin
          beat_d = '0;
          if (occ_next == 2'd0) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Sequence and statistics counters; all wrap silently.
  always_comb begin
    seq_d       = seq_q + SEQ_W'(wr_accept);
    frame_cnt_d = frame_cnt_q + 32'(last_hs);
    drop_cnt_d  = drop_cnt_q + 32'(capture & ~wr_accept);
  end

  // State and counter registers.
  always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
    if (!xdma_resetn) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tlast  = m_axis_tvalid & (beat_q == LAST_BEAT);
  assign m_axis_tdata  = m_axis_tvalid ? rd_data : '0;
  assign m_axis_tkeep  = '1;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = (occ != 2'd0);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dma_io_packer.sv
// Directed bench for dma_io_packer with a beat scoreboard and protocol monitor.
module tb_dma_io_packer;
  import dma_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_enable;
  logic              in_step;
  logic [4063:0]     in_io_data;
  logic [511:0]      tdata;
  logic [63:0]       tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic [31:0]       frame_cnt;
  logic [31:0]       drop_cnt;
  logic              busy;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_q[$];
  int           m_occ, m_beat, m_frames, m_drop;
  logic [31:0]  m_seq;
  logic         prev_stall;
  logic [511:0] prev_data;
  logic         prev_last;

  dma_io_packer dut (
    .xdma_clk      (clk),
    .xdma_resetn   (rst_n),
    .in_enable     (in_enable),
    .in_step       (in_step),
    .in_io_data    (in_io_data),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < 127; w++) in_io_data[w*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic capture_one();
    in_step = 1'b1;
    tick();
    in_step = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // Monitor/scoreboard: samples on the falling edge, predicts what the next
  // rising edge will do and compares every transferred beat.
  always @(negedge clk) begin
    logic [4095:0] fr;
    logic [511:0]  e;
    logic          hs_n, last_now;
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0; m_beat = 0; m_frames = 0; m_drop = 0; m_seq = '0;
      prev_stall = 1'b0;
    end else begin
      check("tvalid_vs_occ", tvalid, (m_occ != 0));
      check("busy", busy, (m_occ != 0));
      check("frame_cnt", frame_cnt, m_frames);
      check("drop_cnt", drop_cnt, m_drop);
      check("tkeep", tkeep, {64{1'b1}});
      if (prev_stall) begin
        check("hold_valid", tvalid, 1'b1);
        check("hold_data", tdata, prev_data);
        check("hold_last", tlast, prev_last);
      end
      hs_n     = tvalid & tready;
      last_now = 1'b0;
      if (hs_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", tdata, e);
        end
        check("tlast", tlast, (m_beat == 7));
        if (m_beat == 7) begin
          last_now = 1'b1;
          m_beat   = 0;
          m_frames++;
        end else begin
          m_beat++;
        end
      end
      if (in_step && in_enable) begin
        if (m_occ < 2 || last_now) begin
          fr = {m_seq, in_io_data};
          for (int k = 0; k < 8; k++) exp_q.push_back(fr[k*512 +: 512]);
          m_seq++;
          m_occ++;
        end else begin
          m_drop++;
        end
      end
      if (last_now) m_occ--;
      prev_stall = tvalid & ~tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  initial begin
    logic [4063:0] pat;
    logic [511:0]  beat0_pat;
    int            cycles;
    for (int i = 0; i < 4064; i++) pat[i] = i[0];
    beat0_pat = {256{2'b10}};

    rst_n = 1'b0; in_enable = 1'b0; in_step = 1'b0; in_io_data = '0; tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, '0);
    check("rst_tkeep", tkeep, {64{1'b1}});
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // single frame, alternating bit pattern
    in_io_data = pat; in_enable = 1'b1;
    capture_one();
    for (int k = 0; k < 8; k++) begin
      check("sf_tvalid", tvalid, 1'b1);
      check("sf_tlast", tlast, (k == 7));
      if (k == 0) check("sf_beat0", tdata, beat0_pat);
      if (k == 7) check("sf_seq0", tdata[511:480], 32'd0);
      tick();
    end
    check("sf_done_tvalid", tvalid, 1'b0);
    check("sf_frame_cnt", frame_cnt, 1);
    check("sf_busy", busy, 1'b0);

    // backpressure: tready toggles every cycle
    tready = 1'b0;
    capture_one();
    cycles = 0;
    while (frame_cnt != 2 && cycles < 40) begin
      tready = ~tready;
      tick();
      cycles++;
    end
    check("bp_frame_cnt", frame_cnt, 2);
    check("bp_cycles", cycles, 15);
    tready = 1'b1;

    // step without enable is ignored
    in_enable = 1'b0;
    capture_one();
    tick();
    check("noen_busy", busy, 1'b0);
    check("noen_tvalid", tvalid, 1'b0);
    in_enable = 1'b1;

    // overflow: three captures while the sink stalls
    do_reset();
    tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      capture_one();
      tick();
    end
    check("ov_drop_cnt", drop_cnt, 1);
    check("ov_busy", busy, 1'b1);
    tready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      check("ov_nogap", tvalid, 1'b1);
      check("ov_tlast", tlast, (c == 7 || c == 15));
      tick();
    end
    check("ov_idle", tvalid, 1'b0);
    check("ov_frame_cnt", frame_cnt, 2);

    // capture coinciding with the last-beat handshake while full
    tready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rand_data();
      capture_one();
    end
    tready = 1'b1;
    repeat (7) tick();
    check("sim_tlast", tlast, 1'b1);
    rand_data();
    capture_one();
    check("sim_drop_cnt", drop_cnt, 1);
    check("sim_busy", busy, 1'b1);
    wait_idle(64);
    check("sim_frame_cnt", frame_cnt, 5);

    // reset in the middle of a frame
    rand_data();
    capture_one();
    repeat (3) tick();
    check("mid_tvalid", tvalid, 1'b1);
    check("mid_tlast", tlast, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 1'b0);
    check("arst_tdata", tdata, '0);
    check("arst_tlast", tlast, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_frame_cnt", frame_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rand_data();
    capture_one();
    wait_idle(32);
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("post_rst_queue", exp_q.size(), 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
